// File: rtl/median9_seq_if.sv
// median9_seq_if: window-load strobes, sort request and median/adaptive results
interface median9_seq_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] pix_in;
    logic              ld_en;
    logic [3:0]        ld_idx;
    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] median_out;
    logic [DATA_W-1:0] pix_out;
    logic              impulse;
    modport master (output pix_in, ld_en, ld_idx, start,
                    input  busy, done, median_out, pix_out, impulse);
    modport slave  (input  pix_in, ld_en, ld_idx, start,
                    output busy, done, median_out, pix_out, impulse);
endinterface

// File: rtl/median9_seq.sv
// median9_seq: 3x3 window median via 9-phase odd-even transposition sort,
// with salt-and-pepper replacement of impulse centre pixels
module median9_seq #(parameter int DATA_W = 8) (
    input logic          clock,
    input logic          reset,
    median9_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SORT, FINISH} state_t;
    state_t            state, state_nxt;
    logic [DATA_W-1:0] win [9];
    logic [DATA_W-1:0] nxt [9];
    logic [DATA_W-1:0] centre_raw, median_q, pix_q;
    logic [3:0]        phase_cnt;
    logic              busy_q, done_q, impulse_q, impulse_nxt;
    always_comb begin
        state_nxt = (state == IDLE && bus.start)           ? SORT   :
                    (state == SORT && phase_cnt == 4'd8)   ? FINISH :
                    (state == FINISH)                      ? IDLE   : state;
        impulse_nxt = (centre_raw == '0) || (centre_raw == '1);
    end
    // pairs are disjoint within a phase, so sequential writes never collide
    always_comb begin
        nxt = win;
        for (int i = 0; i < 8; i++)
            if (i[0] == phase_cnt[0] && win[i] > win[i+1]) begin
                nxt[i]   = win[i+1];
                nxt[i+1] = win[i];
            end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            for (int i = 0; i < 9; i++) win[i] <= '0;
            centre_raw <= '0;
            median_q   <= '0;
            pix_q      <= '0;
            phase_cnt  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            impulse_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= state == FINISH;
            if (state == IDLE && bus.ld_en && bus.ld_idx < 4'd9) begin
                win[bus.ld_idx] <= bus.pix_in;
                if (bus.ld_idx == 4'd4) centre_raw <= bus.pix_in;
            end
            if (state == IDLE && bus.start) begin
                phase_cnt <= '0;
                busy_q    <= 1'b1;
            end
            if (state == SORT) begin
                win       <= nxt;
                phase_cnt <= phase_cnt + 4'd1;
            end
            if (state == FINISH) begin
                median_q  <= win[4];
                impulse_q <= impulse_nxt;
                pix_q     <= impulse_nxt ? win[4] : centre_raw;
                busy_q    <= 1'b0;
            end
        end
    end
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.median_out = median_q;
    assign bus.pix_out    = pix_q;
    assign bus.impulse    = impulse_q;
endmodule

// File: tb/tb_median9_seq.sv
// tb_median9_seq: directed windows with hand-computed medians, scoreboard-checked on done
module tb_median9_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    median9_seq_if #(.DATA_W(8)) bus ();
    median9_seq #(.DATA_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct { logic [7:0] med; logic [7:0] pix; logic imp; } exp_t;
    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("median_out", 32'(bus.median_out), 32'(e.med));
                chk("pix_out",    32'(bus.pix_out),    32'(e.pix));
                chk("impulse",    32'(bus.impulse),    32'(e.imp));
                chk("busy_on_done", 32'(bus.busy), 0);
            end
        end
    end

    task automatic load(input logic [7:0] v [9]);
        for (int i = 0; i < 9; i++) begin
            bus.ld_en = 1'b1; bus.ld_idx = 4'(i); bus.pix_in = v[i];
            @(posedge clock); #1;
        end
        bus.ld_en = 1'b0;
    endtask

    task automatic fill(input logic [7:0] x, output logic [7:0] v [9]);
        for (int i = 0; i < 9; i++) v[i] = x;
    endtask

    // issue start, then check latency and busy width; returns at #1 after the done edge
    task automatic go(input logic [7:0] med, input logic [7:0] pix, input logic imp);
        int n, nb;
        sb.push_back('{med, pix, imp});
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        n = 0; nb = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) nb++;
            @(posedge clock); #1;
            n++;
        end
        chk("done_latency", 32'(n), 10);
        chk("busy_cycles", 32'(nb), 10);
    endtask

    initial begin
        logic [7:0] w [9];
        int dc;
        bus.pix_in = '0; bus.ld_en = 1'b0; bus.ld_idx = '0; bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_median", 32'(bus.median_out), 0);
        chk("rst_pix", 32'(bus.pix_out), 0);
        chk("rst_impulse", 32'(bus.impulse), 0);

        w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd255, 8'd60, 8'd70, 8'd80, 8'd90};
        load(w); go(8'd60, 8'd60, 1'b1);
        // back-to-back start on the done cycle: sorted window, same median
        go(8'd60, 8'd60, 1'b1);

        w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load(w); go(8'd5, 8'd5, 1'b0);

        fill(8'd0, w); load(w); go(8'd0, 8'd0, 1'b1);
        fill(8'd255, w); w[4] = 8'd0; load(w); go(8'd255, 8'd255, 1'b1);

        // load and start in the same cycle: centre 0 written before sorting
        fill(8'd50, w); w[4] = 8'd7; load(w);
        bus.ld_en = 1'b1; bus.ld_idx = 4'd4; bus.pix_in = 8'd0;
        sb.push_back('{8'd50, 8'd50, 1'b1});
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.ld_en = 1'b0;
        repeat (12) @(posedge clock); #1;

        // load and start during SORT must be ignored
        w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd255, 8'd60, 8'd70, 8'd80, 8'd90};
        load(w);
        dc = done_cnt;
        sb.push_back('{8'd60, 8'd60, 1'b1});
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        bus.ld_en = 1'b1; bus.ld_idx = 4'd2; bus.pix_in = 8'd0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.ld_en = 1'b0; bus.start = 1'b0;
        repeat (25) @(posedge clock); #1;
        chk("single_done", 32'(done_cnt - dc), 1);
        chk("sb_empty", 32'(sb.size()), 0);

        // reset at phase 4 abandons the sort
        load(w);
        dc = done_cnt;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_median", 32'(bus.median_out), 0);
        repeat (15) @(posedge clock); #1;
        chk("midrst_no_done", 32'(done_cnt - dc), 0);
        fill(8'd100, w); load(w); go(8'd100, 8'd100, 1'b0);

        // out-of-range slot index is ignored
        fill(8'd50, w); load(w);
        bus.ld_en = 1'b1; bus.ld_idx = 4'd12; bus.pix_in = 8'd0;
        @(posedge clock); #1;
        bus.ld_en = 1'b0;
        go(8'd50, 8'd50, 1'b0);

        repeat (3) @(posedge clock); #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
